// File: rtl/key_pkg.sv
// Shared definitions for the key front end: per-key FSM state encoding and
// default 50 MHz timing constants.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;   // 20 ms at 50 MHz
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 50_000_000;  // 1 s at 50 MHz

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, debounce FSM and registered press/release pulses.
// Optional long-press hold counter is built when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_param
    $error("key_debounce: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
  end

  logic [1:0]  sync_reg;
  key_state_t  state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        level_reg, level_next;
  logic        press_reg, press_next;
  logic        release_reg, release_next;
  logic        s2;

  assign s2 = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], key_n};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!s2) begin
          state_next = DB_PRESS;
          cnt_next   = '0;
        end
      end
      DB_PRESS: begin
        if (s2) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = PRESSED;
          press_next = 1'b1;
          level_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      PRESSED: begin
        if (s2) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        // A short low blip returns to PRESSED without a new press event.
        if (!s2) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
          level_next   = 1'b0;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);

  logic [31:0] hold_reg, hold_next;
  logic        long_reg, long_next;

  // Hold counter saturates one past LONG_LAST so the pulse fires once per press.
  always_comb begin
    hold_next = hold_reg;
    long_next = 1'b0;
    if (state_reg == DB_PRESS && state_next == PRESSED) begin
      hold_next = '0;
    end else if (state_reg == PRESSED || state_reg == DB_RELEASE) begin
      if (hold_reg < LONG_LAST) begin
        hold_next = hold_reg + 32'd1;
      end else if (hold_reg == LONG_LAST) begin
        long_next = 1'b1;
        hold_next = hold_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      long_reg <= long_next;
    end
  end

  assign key_long = long_reg;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Debounced key front end: NUM_KEYS independent key_debounce channels plus any_event.
// Long-press events are enabled by defining KEY_LONG_PRESS_EN.
module key_scan
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                any_event
);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key (
      .clk        (clk),
      .rst        (rst),
      .key_n      (keys_n[gi]),
      .key_level  (key_level[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi]),
      .key_long   (key_long[gi])
    );
  end

  assign any_event = |{key_press, key_release, key_long};

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: behavioural debounce model checked every cycle, directed
// scenarios with literal latencies, then randomized key activity.
module tb_key_scan;

  localparam int N = 3;
  localparam int D = 8;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] keys_n = '1;
  logic [N-1:0] key_level, key_press, key_release, key_long;
  logic         any_event;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  key_scan #(
    .NUM_KEYS         (N),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_n     (keys_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .any_event  (any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: a key flips its accepted level once the synchronised pin has
  // disagreed with it for D+1 consecutive observed cycles.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  int           m_run  [N];
  int           m_hold [N];

  always @(posedge clk) begin
    logic obs_p, was_l;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_level = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        obs_p = ~m_s2[i];
        was_l = m_level[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
        if (obs_p != was_l) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_level[i] = obs_p;
            m_run[i]   = 0;
            if (obs_p) m_press[i] = 1'b1;
            else       m_rel[i]   = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
`ifdef KEY_LONG_PRESS_EN
        // Hold time counts every cycle the key is accepted as down.
        if (!was_l && m_level[i]) m_hold[i] = 0;
        else if (was_l) begin
          if (m_hold[i] == L - 1) begin
            m_long[i] = 1'b1;
            m_hold[i]++;
          end else if (m_hold[i] < L - 1) begin
            m_hold[i]++;
          end
        end
`endif
        m_s2[i] = m_s1[i];
        m_s1[i] = keys_n[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("level",   {29'd0, key_level},   {29'd0, m_level});
      chk("press",   {29'd0, key_press},   {29'd0, m_press});
      chk("release", {29'd0, key_release}, {29'd0, m_rel});
      chk("long",    {29'd0, key_long},    {29'd0, m_long});
      chk("any",     {31'd0, any_event},   {31'd0, |{m_press, m_rel, m_long}});
    end
  end

  // which: 0 press, 1 release, 2 long. Returns edge count or -1 on timeout.
  task automatic wait_pulse(input int key, input int which, input int limit, output int edges);
    logic [N-1:0] v;
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      v = (which == 0) ? key_press : (which == 1) ? key_release : key_long;
      if (v[key]) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    keys_n = '1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int e, np, nl, fl;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_level", {29'd0, key_level}, 32'd0);
    chk("reset_any", {31'd0, any_event}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean press on key 0, then clean release
    keys_n[0] = 1'b0;
    wait_pulse(0, 0, 30, e);
    chk("clean_press_lat", e, 11);
    chk("clean_press_level", {31'd0, key_level[0]}, 1);
    chk("clean_press_any", {31'd0, any_event}, 1);
    @(posedge clk); #1;
    chk("clean_press_once", {31'd0, key_press[0]}, 0);
    @(negedge clk);
    keys_n[0] = 1'b1;
    wait_pulse(0, 1, 30, e);
    chk("clean_release_lat", e, 11);
    settle();

    // Glitch reject on key 1
    keys_n[1] = 1'b0;
    repeat (5) @(negedge clk);
    keys_n[1] = 1'b1;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (key_press[1]) np++;
    end
    chk("glitch_press", np, 0);
    chk("glitch_level", {31'd0, key_level[1]}, 0);
    settle();

    // Release bounce on key 0
    keys_n[0] = 1'b0;
    wait_pulse(0, 0, 30, e);
    @(negedge clk);
    keys_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    keys_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    keys_n[0] = 1'b1;
    np = 0; e = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (key_press[0]) np++;
      if (key_release[0] && e < 0) e = k;
    end
    chk("bounce_release_lat", e, 11);
    chk("bounce_no_press", np, 0);
    settle();

    // Simultaneous keys
    keys_n = '0;
    wait_pulse(0, 0, 30, e);
    chk("simul_lat", e, 11);
    chk("simul_press", {29'd0, key_press}, 32'd7);
    settle();

    // Reset mid-debounce on key 2 (cnt reaches 5 after edge 8)
    keys_n[2] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_outputs", {key_level, key_press, key_release, key_long, any_event}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(2, 0, 30, e);
    chk("rst_repress_lat", e, 11);
    settle();

    // Long press on key 0
    keys_n[0] = 1'b0;
    wait_pulse(0, 0, 30, e);
    nl = 0; fl = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (key_long[0]) begin
        nl++;
        if (fl < 0) fl = k;
      end
    end
`ifdef KEY_LONG_PRESS_EN
    chk("long_count", nl, 1);
    chk("long_lat", fl, 20);
`else
    chk("long_count", nl, 0);
`endif
    settle();

    // Randomized activity: alternating fast-bounce and slow-hold phases
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 500) % 2 == 0) ? 4 : 40;
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, p - 1) == 0) keys_n[i] = ~keys_n[i];
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
Debounced push-button front end for the w5300 debug board. It is the input-side counterpart to the LED status driver: a human drives the keys, and the design consumes clean levels and one-cycle events. Raw active-low key pins are synchronised and debounced per key. The block emits press/release pulses that the test controller uses to trigger socket open, send and reset actions.

Parameters:
NUM_KEYS, 3, number of independent keys
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); must be >= 2
LONG_PRESS_CYCLES, 50_000_000, hold time in cycles for the long-press event (1 s at 50 MHz); only used with the optional feature

Ports:
clk  input  1  system clock, 50 MHz XTAL; the only clock
rst  input  1  reset, synchronous, active-high
keys_n  input  NUM_KEYS  raw key pins, asynchronous, active-low (0 = pressed)
key_level  output  NUM_KEYS  debounced state, 1 = pressed
key_press  output  NUM_KEYS  one-cycle pulse on accepted press
key_release  output  NUM_KEYS  one-cycle pulse on accepted release
key_long  output  NUM_KEYS  one-cycle pulse on long-press; constant 0 without the feature
any_event  output  1  OR of all key_press, key_release and key_long bits, same cycle

Behaviour:
- Reset (rst=1 at a clk edge): sync flops <= 1 (released); every key FSM <= IDLE; counters <= 0; all outputs <= 0. Reset has priority over every other event.
- Synchroniser: 2 flops per key; s2 is the synchronised sample. Pin-to-s2 latency is 2 edges.
- Per-key FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE. Counter is 32-bit, unsigned.
  - IDLE: s2=0 -> DB_PRESS, cnt <= 0.
  - DB_PRESS:
    - s2=1 -> IDLE, cnt <= 0 (glitch rejected, no event).
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, key_press pulse, key_level <= 1, cnt <= 0.
    - Otherwise cnt <= cnt+1.
  - PRESSED: s2=1 -> DB_RELEASE, cnt <= 0.
  - DB_RELEASE:
    - s2=0 -> PRESSED (glitch; no new key_press).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, key_release pulse, key_level <= 0.
    - Otherwise cnt <= cnt+1.
- Latency: with a pin held stable from edge 1 (the first edge sampling the new value), key_press rises after edge DEBOUNCE_CYCLES+3 and lasts exactly one cycle. key_release latency is identical.
- All outputs are registered. Keys are fully independent, so simultaneous events on several keys pulse in the same cycle.
- A key held through reset is re-detected as a fresh press DEBOUNCE_CYCLES+3 edges after rst deasserts.
- Pulses never repeat while the state is held.

Optional Feature:
Macro: KEY_LONG_PRESS_EN
- Defined:
  - A 32-bit hold counter per key clears on entry to PRESSED and increments in PRESSED and DB_RELEASE.
  - When it reaches LONG_PRESS_CYCLES-1, key_long pulses once and the counter saturates; there is no further pulse until the next accepted press.
  - A DB_RELEASE glitch back to PRESSED does not clear the hold counter.
- Undefined: no hold counter is instantiated, and key_long is tied to 0.

Decomposition:
- Shared package/header key_pkg:
  - FSM state encodings (2-bit localparams IDLE=0, DB_PRESS=1, PRESSED=2, DB_RELEASE=3).
  - Default cycle constants for 50 MHz.
- Sub-module key_debounce: one key, consisting of the synchroniser, FSM, counters and optional long-press logic.
- key_scan instantiates NUM_KEYS copies via generate and forms any_event.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8 and LONG_PRESS_CYCLES=20.
- Clean press: keys_n[0] 1->0 sampled at edge 1 and held -> key_press[0]=1 only in the cycle after edge 11; key_level[0]=1 from then; any_event=1 in the same cycle.
- Glitch reject: keys_n[1] low for 5 cycles then high -> no key_press, key_level[1] stays 0, FSM returns to IDLE.
- Release bounce: while pressed, pin high 3 cycles, low 2, then high and held -> single key_release 11 edges after the final rise; no extra key_press.
- Simultaneous keys: keys_n=3'b000 in one cycle -> key_press=3'b111 in the same cycle.
- Reset mid-debounce: rst=1 at cnt=5 with the key still low, then rst=0 -> all outputs 0 during reset; key_press 11 edges after deassert.
- Long press (KEY_LONG_PRESS_EN): hold 40 cycles after the press is accepted -> exactly one key_long pulse, 20 cycles after the press pulse; none without the macro.
